clk_monitor: RTL and testbench
==============================

CLK_MONITOR -- requirements
Module: clk_monitor

Interface
REQ-001 Parameter CNT_W, default 8: width of the period counter and the period output.
REQ-002 Parameter TIMEOUT, default 16: number of mclk cycles without a detected bclk rising edge that declares bclk lost; legal range 2 .. 2^CNT_W-2.
REQ-003 mclk  input  1  monitor clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 bclk  input  1  monitored (buffered) clock, asynchronous to mclk; treated as data, never used as a clock.
REQ-006 en  input  1  monitor enable, synchronous to mclk.
REQ-007 clk_ok  output  1  high while bclk is measured as running.
REQ-008 clk_lost  output  1  one-cycle pulse on each transition into LOST.
REQ-009 period  output  CNT_W  mclk cycles between the last two bclk rising edges.
REQ-010 period_valid  output  1  one-cycle pulse when period is updated.
REQ-011 loss_count  output  8  count of loss events, saturating at 255.

Function
REQ-012 The block SHALL sample bclk through a 2-flop synchronizer followed by a third delay flop; edge = sync2 & ~sync3.
REQ-013 Edge detection latency SHALL be fixed: the FSM acts on an edge in the 3rd mclk cycle after the mclk edge that first samples bclk high.
REQ-014 Accurate measurement SHALL require bclk high and low phases each >= 2 mclk cycles; faster bclk is out of scope (no error flag).
REQ-015 The FSM SHALL have states IDLE, ACQUIRE, RUN, LOST, all registered.
REQ-016 IDLE: cnt held at 0; en=1 -> ACQUIRE next cycle.
REQ-017 ACQUIRE: edge -> RUN with cnt <= 0, no period_valid (no prior edge); timeout -> LOST.
REQ-018 RUN: edge -> period <= cnt+1, period_valid pulse, cnt <= 0, stay RUN; timeout -> LOST.
REQ-019 LOST: edge -> RUN with cnt <= 0, no period_valid (gap exceeded timeout); otherwise stay LOST.
REQ-020 Outside edge cycles cnt SHALL increment by 1, saturating at 2^CNT_W-1; period SHALL saturate at 2^CNT_W-1.
REQ-021 Timeout SHALL occur in the cycle where no edge is detected and cnt == TIMEOUT-1 (TIMEOUT cycles after the last edge or after entering ACQUIRE).
REQ-022 Simultaneous edge and timeout: edge SHALL win; no transition to LOST.
REQ-023 On entry to LOST: clk_lost pulses high one cycle, loss_count increments (saturating at 255).
REQ-024 clk_ok SHALL be high exactly when state is RUN and at least one period_valid has occurred since leaving IDLE/LOST.
REQ-025 en=0 in any state SHALL force IDLE next cycle, clear cnt, drop clk_ok; period and loss_count hold.
REQ-026 All outputs SHALL be registered; no combinational path from bclk or en to any output.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, synchronizer flops 0, cnt 0, clk_ok 0, clk_lost 0, period 0, period_valid 0, loss_count 0.
REQ-028 Reset release SHALL take effect on the next mclk rising edge; rst asserted mid-RUN SHALL abort measurement with no pulse emitted.

Verification (CNT_W=8, TIMEOUT=16)
REQ-029 rst pulse, en=1, bclk = mclk/4 (2 high, 2 low) -> first period_valid on second detected edge, period=4, clk_ok=1 from that cycle onward.
REQ-030 bclk switched to mclk/10 while in RUN -> first full interval gives period=10 with period_valid; clk_ok stays 1 throughout.
REQ-031 bclk held low after an edge -> clk_lost pulses exactly 16 cycles after that edge; clk_ok=0; loss_count=1; period holds last value.
REQ-032 bclk restarted at mclk/4 from LOST -> first edge enters RUN without period_valid; next edge gives period=4 and clk_ok=1.
REQ-033 en=0 for 5 cycles mid-RUN, then en=1 -> IDLE with clk_ok=0 the next cycle; period unchanged; after re-enable, ACQUIRE then period=4.
REQ-034 rst asserted asynchronously mid-RUN (between mclk edges) -> all outputs 0 before the next mclk edge; loss_count=0.

Source files
------------

// File: rtl/clk_monitor.sv
// -----------------------------------------------------------------------------
// clk_monitor
//   Watches a buffered clock (bclk) from the monitor clock domain (mclk). bclk
//   is only ever sampled as data. The block measures the bclk period in mclk
//   cycles and reports the clock as lost when no rising edge arrives within
//   TIMEOUT mclk cycles.
//
// Parameters
//   CNT_W    width of the interval counter and the period output
//   TIMEOUT  mclk cycles with no bclk rising edge before bclk is declared lost
//            (legal range 2 .. 2**CNT_W-2)
//
// Ports
//   mclk          monitor clock; all state changes on its rising edge
//   rst           asynchronous active-high reset
//   bclk          monitored clock, asynchronous to mclk
//   en            monitor enable, synchronous to mclk
//   clk_ok        high while bclk is measured as running
//   clk_lost      one-cycle pulse on each entry into LOST
//   period        mclk cycles between the last two bclk rising edges
//   period_valid  one-cycle pulse when period is updated
//   loss_count    number of loss events, saturating at 255
// -----------------------------------------------------------------------------
module clk_monitor #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic             bclk,
  input  logic             en,
  output logic             clk_ok,
  output logic             clk_lost,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic [7:0]       loss_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    RUN     = 2'd2,
    LOST    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  // sync_q[0], sync_q[1] form the synchronizer; sync_q[2] is the delay flop
  // used for edge detection.
  logic [2:0]       sync_q, sync_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             clk_ok_q, clk_ok_d;
  logic             clk_lost_q, clk_lost_d;
  logic             period_valid_q, period_valid_d;
  logic [7:0]       loss_count_q, loss_count_d;

  logic             bclk_rise;
  logic             timeout;
  logic [CNT_W-1:0] cnt_inc;

  assign bclk_rise = sync_q[1] & ~sync_q[2];
  // An edge in the timeout cycle takes priority, so the timeout term
  // excludes it.
  assign timeout   = ~bclk_rise && (cnt_q == TO_LAST);
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    sync_d         = {sync_q[1:0], bclk};
    state_d        = state_q;
    cnt_d          = cnt_inc;
    period_d       = period_q;
    clk_ok_d       = clk_ok_q;
    clk_lost_d     = 1'b0;
    period_valid_d = 1'b0;
    loss_count_d   = loss_count_q;

    if (!en) begin
      // Disabling aborts any measurement; period and loss_count are kept.
      state_d  = IDLE;
      cnt_d    = '0;
      clk_ok_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d    = '0;
          clk_ok_d = 1'b0;
          state_d  = ACQUIRE;
        end
        ACQUIRE: begin
          clk_ok_d = 1'b0;
          if (bclk_rise) begin
            // First edge only opens the interval; nothing to report yet.
            state_d = RUN;
            cnt_d   = '0;
          end else if (timeout) begin
            state_d      = LOST;
            clk_lost_d   = 1'b1;
            loss_count_d = (loss_count_q == 8'hFF) ? loss_count_q
                                                   : loss_count_q + 8'd1;
          end
        end
        RUN: begin
          if (bclk_rise) begin
            period_d       = cnt_inc;  // cnt+1, saturating
            period_valid_d = 1'b1;
            clk_ok_d       = 1'b1;
            cnt_d          = '0;
          end else if (timeout) begin
            state_d      = LOST;
            clk_ok_d     = 1'b0;
            clk_lost_d   = 1'b1;
            loss_count_d = (loss_count_q == 8'hFF) ? loss_count_q
                                                   : loss_count_q + 8'd1;
          end
        end
        LOST: begin
          clk_ok_d = 1'b0;
          if (bclk_rise) begin
            // The gap before this edge exceeded the timeout, so it is not a
            // valid period; restart the interval instead.
            state_d = RUN;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d  = IDLE;
          cnt_d    = '0;
          clk_ok_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      sync_q         <= '0;
      state_q        <= IDLE;
      cnt_q          <= '0;
      period_q       <= '0;
      clk_ok_q       <= 1'b0;
      clk_lost_q     <= 1'b0;
      period_valid_q <= 1'b0;
      loss_count_q   <= '0;
    end else begin
      sync_q         <= sync_d;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      clk_ok_q       <= clk_ok_d;
      clk_lost_q     <= clk_lost_d;
      period_valid_q <= period_valid_d;
      loss_count_q   <= loss_count_d;
    end
  end

  assign clk_ok       = clk_ok_q;
  assign clk_lost     = clk_lost_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign loss_count   = loss_count_q;

endmodule

// File: tb/tb_clk_monitor.sv
// -----------------------------------------------------------------------------
// tb_clk_monitor
//   Scoreboard bench for clk_monitor (CNT_W=8, TIMEOUT=16). Stimulus pushes
//   hand-computed expected periods and loss events into queues; a monitor
//   process pops and compares whenever period_valid or clk_lost pulses.
// -----------------------------------------------------------------------------
module tb_clk_monitor;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 16;

  logic             mclk = 1'b0;
  logic             rst  = 1'b1;
  logic             bclk = 1'b0;
  logic             en   = 1'b0;
  logic             clk_ok;
  logic             clk_lost;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic [7:0]       loss_count;

  clk_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .mclk         (mclk),
    .rst          (rst),
    .bclk         (bclk),
    .en           (en),
    .clk_ok       (clk_ok),
    .clk_lost     (clk_lost),
    .period       (period),
    .period_valid (period_valid),
    .loss_count   (loss_count)
  );

  always #5 mclk = ~mclk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_pv_cyc = 0;
  bit ok_steady = 1'b0;

  int exp_period_q[$];
  int exp_loss_q[$];
  int exp_hold_q[$];

  always @(posedge mclk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end else begin
      $display("ok   %s: %0d (cycle %0d)", name, actual, cyc);
    end
  endtask

  // Monitor: compares DUT output events against the scoreboard queues.
  always @(negedge mclk) begin
    if (!rst) begin
      if (period_valid) begin
        last_pv_cyc = cyc;
        if (exp_period_q.size() == 0) begin
          check("unexpected_period_valid", 1, 0);
        end else begin
          check("period", int'(period), exp_period_q.pop_front());
          check("clk_ok_at_pv", int'(clk_ok), 1);
        end
      end
      if (clk_lost) begin
        if (exp_loss_q.size() == 0) begin
          check("unexpected_clk_lost", 1, 0);
        end else begin
          check("loss_count", int'(loss_count), exp_loss_q.pop_front());
          check("period_hold_at_loss", int'(period), exp_hold_q.pop_front());
          check("clk_ok_at_loss", int'(clk_ok), 0);
          check("loss_gap", cyc - last_pv_cyc, TIMEOUT);
        end
      end
      if (ok_steady) check("clk_ok_steady", int'(clk_ok), 1);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge mclk);
      #1;
    end
  endtask

  task automatic run_bclk(input int hi, input int lo, input int n);
    repeat (n) begin
      bclk = 1'b1;
      tick(hi);
      bclk = 1'b0;
      tick(lo);
    end
  endtask

  task automatic push_periods(input int p, input int n);
    repeat (n) exp_period_q.push_back(p);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(3);
    check("rst_clk_ok", int'(clk_ok), 0);
    check("rst_clk_lost", int'(clk_lost), 0);
    check("rst_period", int'(period), 0);
    check("rst_period_valid", int'(period_valid), 0);
    check("rst_loss_count", int'(loss_count), 0);
    rst = 1'b0;
    tick(2);

    // mclk/4: first edge acquires, following edges report period 4
    en = 1'b1;
    push_periods(4, 5);
    run_bclk(2, 2, 6);
    check("clk_ok_after_acquire", int'(clk_ok), 1);

    // Switch to mclk/10 then to mclk/16 (edge coincides with timeout cycle)
    ok_steady = 1'b1;
    exp_period_q.push_back(4);
    push_periods(10, 2);
    run_bclk(5, 5, 3);
    exp_period_q.push_back(10);
    push_periods(16, 2);
    run_bclk(8, 8, 3);
    ok_steady = 1'b0;

    // Hold bclk low: loss 16 cycles after the last edge
    exp_loss_q.push_back(1);
    exp_hold_q.push_back(16);
    tick(20);
    check("clk_ok_lost", int'(clk_ok), 0);

    // Restart from LOST: first edge gives no period
    push_periods(4, 3);
    run_bclk(2, 2, 4);

    // Disable mid-RUN
    en = 1'b0;
    tick(1);
    check("disable_clk_ok", int'(clk_ok), 0);
    check("disable_period_hold", int'(period), 4);
    tick(4);
    check("disable_loss_hold", int'(loss_count), 1);
    en = 1'b1;
    push_periods(4, 3);
    run_bclk(2, 2, 4);

    // Asynchronous reset mid-RUN, between mclk edges
    push_periods(4, 2);
    run_bclk(2, 2, 2);
    bclk = 1'b1;
    tick(1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_clk_ok", int'(clk_ok), 0);
    check("arst_clk_lost", int'(clk_lost), 0);
    check("arst_period", int'(period), 0);
    check("arst_period_valid", int'(period_valid), 0);
    check("arst_loss_count", int'(loss_count), 0);
    tick(2);
    rst = 1'b0;
    bclk = 1'b0;
    tick(3);
    check("no_pulse_after_rst", int'(period_valid), 0);
    check("periods_left", exp_period_q.size(), 0);
    check("losses_left", exp_loss_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
